// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: frequency-sweep sequencer that feeds the phase-increment
// stream (valid + data) of an NCO core. It steps the increment from a start
// value up to an inclusive stop value, holding each value for dwell+1 cycles.
// A sweep is either single-shot (ends with a done pulse) or continuous (wraps
// back to the start value). Everything runs in the NCO clock domain.
module nco_sweep_ctrl #(
    parameter int PINC_W  = 32,
    parameter int DWELL_W = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [PINC_W-1:0] start_inc,
    input  logic [PINC_W-1:0] stop_inc,
    input  logic [PINC_W-1:0] step_inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic              out_valid,
    output logic [PINC_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Sweep configuration captured on the accepted start edge.
    logic                cont_q;
    logic [PINC_W-1:0]   start_inc_q;
    logic [PINC_W-1:0]   stop_inc_q;
    logic [PINC_W-1:0]   step_inc_q;
    logic [DWELL_W-1:0]  dwell_q;

    // Running state of the sweep.
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [PINC_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    // Step decision helpers.
    logic [PINC_W:0]     sum;
    logic                end_cond;
    logic [PINC_W-1:0]   step_val;
    logic                cfg_load;
    logic                dwell_hit;

    // Config is only meaningful on the start edge taken from IDLE.
    assign cfg_load  = (state_q == S_IDLE) && start;
    assign dwell_hit = (cnt_q == dwell_q);

    // Next sweep value: one extra bit on the sum catches wrap past the top of
    // the increment range; a sum beyond stop is clamped so the final value
    // presented is exactly stop_inc.
    always_comb begin
        sum      = {1'b0, data_q} + {1'b0, step_inc_q};
        end_cond = (data_q >= stop_inc_q) || (step_inc_q == '0) || sum[PINC_W];
        if (sum[PINC_W-1:0] > stop_inc_q) begin
            step_val = stop_inc_q;
        end else begin
            step_val = sum[PINC_W-1:0];
        end
    end

    // Next-state and datapath control; stop outranks any coincident step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    data_d  = start_inc;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (dwell_hit) begin
                    cnt_d = '0;
                    if (!end_cond) begin
                        data_d = step_val;
                    end else if (cont_q) begin
                        data_d = start_inc_q;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, output value and done pulse registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Configuration latch, loaded only when a sweep is launched.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cont_q      <= 1'b0;
            start_inc_q <= '0;
            stop_inc_q  <= '0;
            step_inc_q  <= '0;
            dwell_q     <= '0;
        end else if (cfg_load) begin
            cont_q      <= continuous;
            start_inc_q <= start_inc;
            stop_inc_q  <= stop_inc;
            step_inc_q  <= step_inc;
            dwell_q     <= dwell;
        end
    end

    // The NCO has no backpressure, so valid simply tracks RUN.
    assign out_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign out_data  = data_q;
    assign done      = done_q;

endmodule
